// File: rtl/ulpi_tx_arbiter_pkg.sv
// Shared definitions for the ULPI transmit arbiter: handshake PIDs, grant codes,
// FSM state encodings and small mapping helpers.
package ulpi_tx_arbiter_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_HSK  = 2'd1,
        GNT_S0   = 2'd2,
        GNT_S1   = 2'd3
    } grant_e;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_HSK  = 5'b00010,
        ST_SRC0 = 5'b00100,
        ST_SRC1 = 5'b01000,
        ST_GAP  = 5'b10000
    } state_e;

    function automatic grant_e src_grant(input logic idx);
        return idx ? GNT_S1 : GNT_S0;
    endfunction

    function automatic state_e src_state(input logic idx);
        return idx ? ST_SRC1 : ST_SRC0;
    endfunction

endpackage

// File: rtl/ulpi_tx_arbiter_arb_rr2.sv
// Two-way round-robin picker: the pointer names the preferred source when both
// request; it moves to the other source once a packet has been served.
module arb_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       served_i,
    output logic       pick_valid_o,
    output logic       pick_idx_o
);

    logic ptr_q;
    logic ptr_d;

    // Pointer update and pick from current-cycle requests.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~served_i;
        end else begin
            ptr_d = ptr_q;
        end
        pick_valid_o = |req_i;
        if (req_i == 2'b11) begin
            pick_idx_o = ptr_q;
        end else begin
            pick_idx_o = req_i[1];
        end
    end

    // Pointer register, starts on source 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ulpi_tx_arbiter.sv
// Shares the ULPI encoder transmit stream between a handshake source and two data
// sources: whole-packet grants, handshake priority, round-robin data, fixed gap.
module ulpi_tx_arbiter
    import ulpi_tx_arbiter_pkg::*;
#(
    parameter int IPG_CYCLES = 8,
    parameter int GAP_BITS   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       ulpi_dir,
    input  logic       hsk_tvalid,
    output logic       hsk_tready,
    input  logic [3:0] hsk_tuser,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic       s0_tkeep,
    input  logic       s0_tlast,
    input  logic [3:0] s0_tuser,
    input  logic [7:0] s0_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    input  logic       s1_tkeep,
    input  logic       s1_tlast,
    input  logic [3:0] s1_tuser,
    input  logic [7:0] s1_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tkeep,
    output logic       m_tlast,
    output logic [3:0] m_tuser,
    output logic [7:0] m_tdata,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'(IPG_CYCLES - 1);

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    logic [GAP_BITS-1:0] gap_q, gap_d;
    logic                busy_q, busy_d;

    logic rr_valid_s;
    logic rr_idx_s;
    logic rr_advance_s;
    logic rr_served_s;

    arb_rr2 u_rr (
        .clock        (clock),
        .reset        (reset),
        .req_i        ({s1_tvalid, s0_tvalid}),
        .advance_i    (rr_advance_s),
        .served_i     (rr_served_s),
        .pick_valid_o (rr_valid_s),
        .pick_idx_o   (rr_idx_s)
    );

    // Next-state, grant and gap counter computation.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gap_d        = gap_q;
        rr_advance_s = 1'b0;
        rr_served_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Link state and bus direction only gate new decisions.
                if (enable_i && !ulpi_dir && hsk_tvalid) begin
                    state_d = ST_HSK;
                    grant_d = GNT_HSK;
                end else if (enable_i && !ulpi_dir && rr_valid_s) begin
                    state_d = src_state(rr_idx_s);
                    grant_d = src_grant(rr_idx_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HSK: begin
                if (m_tready) begin
                    state_d = ST_GAP;
                    grant_d = GNT_NONE;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = ST_HSK;
                end
            end
            ST_SRC0, ST_SRC1: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d      = ST_GAP;
                    grant_d      = GNT_NONE;
                    gap_d        = GAP_LOAD;
                    rr_advance_s = 1'b1;
                    rr_served_s  = (state_q == ST_SRC1);
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                if (gap_q == {GAP_BITS{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
                gap_d   = {GAP_BITS{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, grant, gap count and busy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            gap_q   <= {GAP_BITS{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
        end
    end

    // Output mux steered by the registered grant; ungranted sources see no ready.
    always_comb begin
        m_tvalid   = 1'b0;
        m_tkeep    = 1'b0;
        m_tlast    = 1'b0;
        m_tuser    = 4'h0;
        m_tdata    = 8'h00;
        hsk_tready = 1'b0;
        s0_tready  = 1'b0;
        s1_tready  = 1'b0;
        case (grant_q)
            GNT_HSK: begin
                m_tvalid   = 1'b1;
                m_tlast    = 1'b1;
                m_tuser    = hsk_tuser;
                hsk_tready = m_tready;
            end
            GNT_S0: begin
                m_tvalid  = s0_tvalid;
                m_tkeep   = s0_tkeep;
                m_tlast   = s0_tlast;
                m_tuser   = s0_tuser;
                m_tdata   = s0_tdata;
                s0_tready = m_tready;
            end
            GNT_S1: begin
                m_tvalid  = s1_tvalid;
                m_tkeep   = s1_tkeep;
                m_tlast   = s1_tlast;
                m_tuser   = s1_tuser;
                m_tdata   = s1_tdata;
                s1_tready = m_tready;
            end
            default: begin
                m_tvalid = 1'b0;
            end
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// Directed self-checking bench for ulpi_tx_arbiter; inputs change just after the
// rising edge and outputs are sampled on the falling edge.
module tb_ulpi_tx_arbiter;
    import ulpi_tx_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset, enable_i, ulpi_dir;
    logic       hsk_tvalid, hsk_tready;
    logic [3:0] hsk_tuser;
    logic       s0_tvalid, s0_tready, s0_tkeep, s0_tlast;
    logic [3:0] s0_tuser;
    logic [7:0] s0_tdata;
    logic       s1_tvalid, s1_tready, s1_tkeep, s1_tlast;
    logic [3:0] s1_tuser;
    logic [7:0] s1_tdata;
    logic       m_tvalid, m_tready, m_tkeep, m_tlast;
    logic [3:0] m_tuser;
    logic [7:0] m_tdata;
    logic [1:0] grant_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ulpi_tx_arbiter #(.IPG_CYCLES(8), .GAP_BITS(4)) dut (
        .clock(clock), .reset(reset), .enable_i(enable_i), .ulpi_dir(ulpi_dir),
        .hsk_tvalid(hsk_tvalid), .hsk_tready(hsk_tready), .hsk_tuser(hsk_tuser),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tkeep(s0_tkeep),
        .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tdata(s0_tdata),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tkeep(s1_tkeep),
        .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tdata(s1_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdata(m_tdata),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts idle (m_tvalid low) falling edges until m_tvalid rises; ends on that edge.
    task automatic count_gap(input string tag, input int exp);
        int n = 0;
        while (n < 40) begin
            @(negedge clock);
            if (m_tvalid === 1'b1) break;
            n++;
            tick();
        end
        chk(tag, n, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while (busy_o !== 1'b0 && n < 40) begin
            tick();
            @(negedge clock);
            n++;
        end
        chk(tag, busy_o, 1'b0);
    endtask

    logic [7:0] b5 [3] = '{8'hC1, 8'hC2, 8'hC3};
    bit tr_pat  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit bub_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit dir_pat [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] alt_exp [4] = '{2'd2, 2'd3, 2'd2, 2'd3};

    initial begin
        int idx;
        reset = 1'b1; enable_i = 1'b1; ulpi_dir = 1'b0; m_tready = 1'b1;
        hsk_tvalid = 1'b0; hsk_tuser = 4'h0;
        s0_tvalid = 1'b0; s0_tkeep = 1'b1; s0_tlast = 1'b0; s0_tuser = 4'h0; s0_tdata = 8'h00;
        s1_tvalid = 1'b0; s1_tkeep = 1'b1; s1_tlast = 1'b0; s1_tuser = 4'h0; s1_tdata = 8'h00;
        tick(); tick();
        @(negedge clock);
        chk("rst_grant", grant_o, 2'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mbus", {m_tvalid, m_tkeep, m_tlast, m_tuser, m_tdata}, 15'h0);
        chk("rst_ready", {hsk_tready, s0_tready, s1_tready}, 3'b000);

        // s0 three-byte DATA0
        tick(); reset = 1'b0;
        s0_tvalid = 1'b1; s0_tuser = 4'h3; s0_tdata = 8'h11; s0_tlast = 1'b0;
        @(negedge clock);
        chk("t1_pre_valid", m_tvalid, 1'b0);
        chk("t1_pre_ready", s0_tready, 1'b0);
        tick();
        @(negedge clock);
        chk("t1_grant", grant_o, 2'd2);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_b1", {m_tvalid, m_tuser, m_tdata, s0_tready}, {1'b1, 4'h3, 8'h11, 1'b1});
        tick(); s0_tdata = 8'h22;
        @(negedge clock);
        chk("t1_b2", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 8'h22});
        tick(); s0_tdata = 8'h33; s0_tlast = 1'b1;
        @(negedge clock);
        chk("t1_b3", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 8'h33});
        tick(); s0_tdata = 8'h44;
        count_gap("t1_gap", 9);
        chk("t1_regrant", {grant_o, m_tdata}, {2'd2, 8'h44});
        tick(); s0_tvalid = 1'b0; s0_tlast = 1'b0;
        wait_idle("t1_idle");

        // handshake beats a simultaneous s1 request
        tick();
        hsk_tvalid = 1'b1; hsk_tuser = PID_ACK;
        s1_tvalid = 1'b1; s1_tuser = 4'hB; s1_tdata = 8'hA5; s1_tlast = 1'b1;
        @(negedge clock);
        chk("t2_pre", grant_o, 2'd0);
        tick();
        @(negedge clock);
        chk("t2_hsk_grant", grant_o, 2'd1);
        chk("t2_hsk_beat", {m_tvalid, m_tkeep, m_tlast, m_tuser, m_tdata},
            {1'b1, 1'b0, 1'b1, PID_ACK, 8'h00});
        chk("t2_readies", {hsk_tready, s1_tready}, 2'b10);
        tick(); hsk_tvalid = 1'b0;
        count_gap("t2_gap", 9);
        chk("t2_s1", {grant_o, m_tuser, m_tdata}, {2'd3, 4'hB, 8'hA5});
        tick(); s1_tvalid = 1'b0;
        wait_idle("t2_idle");

        // both sources always valid with single-beat packets: strict alternation
        tick();
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 8'h50;
        s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 8'h51;
        count_gap("t3_lat0", 1);
        chk("t3_grant0", grant_o, alt_exp[0]);
        for (int k = 1; k < 4; k++) begin
            tick();
            count_gap("t3_gap", 9);
            chk("t3_grant", grant_o, alt_exp[k]);
        end
        tick(); s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        wait_idle("t3_idle");

        // PHY owns the bus: no grant until dir drops
        tick(); ulpi_dir = 1'b1;
        s0_tvalid = 1'b1; s0_tdata = 8'h77; s0_tlast = 1'b1;
        tick(); tick();
        @(negedge clock);
        chk("t4_blocked", {grant_o, s0_tready, m_tvalid}, {2'd0, 1'b0, 1'b0});
        tick(); ulpi_dir = 1'b0;
        @(negedge clock);
        chk("t4_still_idle", grant_o, 2'd0);
        tick();
        @(negedge clock);
        chk("t4_grant", {grant_o, m_tvalid, m_tdata}, {2'd2, 1'b1, 8'h77});
        tick(); s0_tvalid = 1'b0;
        wait_idle("t4_idle");

        // s1 packet with ready toggles, a bubble, dir pulse and a pending handshake
        idx = 0;
        s1_tuser = 4'hB; s1_tkeep = 1'b1;
        for (int i = 0; i < 30 && idx < 3; i++) begin
            tick();
            m_tready   = (i < 8) ? tr_pat[i] : 1'b1;
            s1_tvalid  = (i < 8) ? bub_pat[i] : 1'b1;
            ulpi_dir   = (i < 8) ? dir_pat[i] : 1'b0;
            hsk_tvalid = (i >= 2);
            hsk_tuser  = PID_ACK;
            s1_tdata   = b5[idx];
            s1_tlast   = (idx == 2);
            @(negedge clock);
            if (s1_tvalid && s1_tready) begin
                chk("t5_grant", grant_o, 2'd3);
                chk("t5_byte", m_tdata, b5[idx]);
                chk("t5_hsk_held", hsk_tready, 1'b0);
                idx++;
            end
        end
        chk("t5_count", idx, 3);
        tick(); s1_tvalid = 1'b0; m_tready = 1'b1; ulpi_dir = 1'b0;
        count_gap("t5_gap", 9);
        chk("t5_ack", {grant_o, m_tuser, m_tkeep, m_tlast}, {2'd1, PID_ACK, 1'b0, 1'b1});
        tick(); hsk_tvalid = 1'b0;
        wait_idle("t5_idle");

        // reset during byte 2 of an s0 packet
        tick(); s0_tvalid = 1'b1; s0_tdata = 8'hD1; s0_tlast = 1'b0;
        tick();
        @(negedge clock);
        chk("t6_b1", m_tdata, 8'hD1);
        tick(); s0_tdata = 8'hD2; reset = 1'b1;
        @(negedge clock);
        chk("t6_b2", m_tdata, 8'hD2);
        tick(); reset = 1'b0; enable_i = 1'b0;
        @(negedge clock);
        chk("t6_flush_bus", {m_tvalid, m_tkeep, m_tlast, m_tuser, m_tdata}, 15'h0);
        chk("t6_flush_state", {grant_o, busy_o, s0_tready}, 4'h0);
        tick();
        @(negedge clock);
        chk("t6_enable_low", {grant_o, busy_o}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
